// File: rtl/viterbi_ctrl_pkg.sv
// Shared parameters for the Viterbi decoder control slice.
// Holds the symbol width, the TB_DEPTH / NORM_PERIOD defaults and the FSM
// state encoding. The MINSRCH state exists only when ZERO_TAIL_EN is undefined.
package viterbi_ctrl_pkg;

  localparam int unsigned SLICED_INPUT_NUM = 3;
  localparam int unsigned TB_DEPTH_DEF     = 32;
  localparam int unsigned NORM_PERIOD_DEF  = 64;
  localparam int unsigned CNT_W            = 16;
  localparam int unsigned ST_W             = 3;

  typedef logic [ST_W-1:0] state_t;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD    = 3'd1;
  localparam logic [ST_W-1:0] ST_RUN     = 3'd2;
  localparam logic [ST_W-1:0] ST_DRAIN   = 3'd3;
  localparam logic [ST_W-1:0] ST_TB      = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE    = 3'd5;
`ifndef ZERO_TAIL_EN
  localparam logic [ST_W-1:0] ST_MINSRCH = 3'd6;
`endif

endpackage

// File: rtl/viterbi_ctrl_norm_cnt.sv
// Path-metric normalization counter.
// Counts ACS strobes one cycle ahead of o_acs_en so that norm rises in the
// same cycle as every NORM_PERIOD-th strobe.
// Ports: clk, rst (async active-low), clr (frame restart), inc (early ACS
// strobe), norm (registered normalize pulse).
module viterbi_norm_cnt
  import viterbi_ctrl_pkg::*;
#(
  parameter int unsigned NORM_PERIOD = NORM_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic norm
);

  localparam int unsigned CW = (NORM_PERIOD > 1) ? $clog2(NORM_PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic          wrap_c;

  assign wrap_c = (cnt == CW'(NORM_PERIOD - 1));

  // Modulo-NORM_PERIOD strobe counter with registered wrap pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      norm <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      norm <= 1'b0;
    end else begin
      norm <= inc & wrap_c;
      if (inc) cnt <= wrap_c ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/viterbi_ctrl.sv
// Viterbi decoder frame controller.
// Accepts a frame of received symbols, forwards them to the branch-metric
// unit, strobes the ACS array two cycles after each handshake, requests
// path-metric normalization and sequences traceback.
// Ports: clk, rst (async active-low); i_start/i_frame_len frame request;
// i_rx_valid/o_rx_ready/i_rx_data symbol input; o_bm_data, o_acs_en,
// o_pm_clr, o_norm datapath controls; o_tb_start/i_tb_done traceback;
// o_busy, o_done, o_sym_cnt status.
// Config: ZERO_TAIL_EN -- traceback from state 0, DRAIN goes straight to TB.
// When undefined, a MINSRCH state waits on i_min_valid before traceback.
module viterbi_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter int unsigned TB_DEPTH    = TB_DEPTH_DEF,
  parameter int unsigned NORM_PERIOD = NORM_PERIOD_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [CNT_W-1:0]            i_frame_len,
  input  logic                        i_rx_valid,
  output logic                        o_rx_ready,
  input  logic [SLICED_INPUT_NUM-1:0] i_rx_data,
  output logic [SLICED_INPUT_NUM-1:0] o_bm_data,
  output logic                        o_acs_en,
  output logic                        o_pm_clr,
  output logic                        o_norm,
  output logic                        o_tb_start,
  input  logic                        i_tb_done,
`ifndef ZERO_TAIL_EN
  input  logic                        i_min_valid,
`endif
  output logic                        o_busy,
  output logic                        o_done,
  output logic [CNT_W-1:0]            o_sym_cnt
);

  state_t             state, state_d;
  logic [CNT_W-1:0]   frame_len;
  logic [CNT_W-1:0]   cnt_d;
  logic               acs_pipe;
  logic               hs_c;
  logic               tb_ok_c;
  logic               rx_ready_d, pm_clr_d, tb_start_d, done_d, busy_d;

  assign hs_c = i_rx_valid & o_rx_ready;

  // Traceback allowed once TB_DEPTH symbols are in, or the whole (short) frame is
  assign tb_ok_c = (32'(o_sym_cnt) >= TB_DEPTH) || (o_sym_cnt == frame_len);

  // Next-state and next-output decode
  always_comb begin
    state_d    = state;
    cnt_d      = o_sym_cnt;
    rx_ready_d = 1'b0;
    pm_clr_d   = 1'b0;
    tb_start_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = 1'b0;

    case (state)
      ST_IDLE:    if (i_start) state_d = ST_LOAD;
      ST_LOAD:    state_d = (frame_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:     if (hs_c && (o_sym_cnt + CNT_W'(1) == frame_len)) state_d = ST_DRAIN;
      // acs_pipe low means the final strobe is on o_acs_en now or already gone
      ST_DRAIN: begin
        if (!acs_pipe && tb_ok_c) begin
`ifdef ZERO_TAIL_EN
          state_d = ST_TB;
`else
          state_d = ST_MINSRCH;
`endif
        end
      end
`ifndef ZERO_TAIL_EN
      ST_MINSRCH: if (i_min_valid) state_d = ST_TB;
`endif
      ST_TB:      if (i_tb_done) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (state_d == ST_LOAD)                  cnt_d = '0;
    else if (hs_c && o_sym_cnt < frame_len)  cnt_d = o_sym_cnt + CNT_W'(1);

    rx_ready_d = (state_d == ST_RUN) && (cnt_d < frame_len);
    pm_clr_d   = (state_d == ST_LOAD);
    tb_start_d = (state_d == ST_TB) && (state != ST_TB);
    done_d     = (state_d == ST_DONE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      frame_len  <= '0;
      o_sym_cnt  <= '0;
      acs_pipe   <= 1'b0;
      o_acs_en   <= 1'b0;
      o_bm_data  <= '0;
      o_rx_ready <= 1'b0;
      o_pm_clr   <= 1'b0;
      o_tb_start <= 1'b0;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_d;
      o_sym_cnt  <= cnt_d;
      acs_pipe   <= hs_c;
      o_acs_en   <= acs_pipe;
      o_rx_ready <= rx_ready_d;
      o_pm_clr   <= pm_clr_d;
      o_tb_start <= tb_start_d;
      o_done     <= done_d;
      o_busy     <= busy_d;
      if (state == ST_IDLE && i_start) frame_len <= i_frame_len;
      if (hs_c)                        o_bm_data <= i_rx_data;
    end
  end

  viterbi_norm_cnt #(
    .NORM_PERIOD (NORM_PERIOD)
  ) u_norm_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_LOAD),
    .inc  (acs_pipe),
    .norm (o_norm)
  );

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Directed bench for viterbi_ctrl: frame sequencing, ACS strobe timing,
// normalization pulses, zero-length frames and mid-frame reset.
module tb_viterbi_ctrl;
  import viterbi_ctrl_pkg::*;

  logic                        clk;
  logic                        rst;
  logic                        i_start;
  logic [CNT_W-1:0]            i_frame_len;
  logic                        i_rx_valid;
  logic                        o_rx_ready;
  logic [SLICED_INPUT_NUM-1:0] i_rx_data;
  logic [SLICED_INPUT_NUM-1:0] o_bm_data;
  logic                        o_acs_en;
  logic                        o_pm_clr;
  logic                        o_norm;
  logic                        o_tb_start;
  logic                        i_tb_done;
  logic                        i_min_valid;
  logic                        o_busy;
  logic                        o_done;
  logic [CNT_W-1:0]            o_sym_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-frame observations, indexed by cycle since the start request
  int          fcyc = 0;
  logic [63:0] acs_log = '0;
  int acs_cnt = 0, norm_cnt = 0, norm_i1 = 0, norm_i2 = 0, norm_orphan = 0;
  int tb_cnt = 0, tb_at = 0, done_cnt = 0, done_at = 0, pmclr_cnt = 0;

`ifdef ZERO_TAIL_EN
  localparam int F1_TB = 8,  F1_DN = 9,  F2_TB = 9,  F2_DN = 10;
`else
  localparam int F1_TB = 15, F1_DN = 16, F2_TB = 10, F2_DN = 11;
`endif

  viterbi_ctrl #(.TB_DEPTH(32), .NORM_PERIOD(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_frame_len (i_frame_len),
    .i_rx_valid  (i_rx_valid),
    .o_rx_ready  (o_rx_ready),
    .i_rx_data   (i_rx_data),
    .o_bm_data   (o_bm_data),
    .o_acs_en    (o_acs_en),
    .o_pm_clr    (o_pm_clr),
    .o_norm      (o_norm),
    .o_tb_start  (o_tb_start),
    .i_tb_done   (i_tb_done),
`ifndef ZERO_TAIL_EN
    .i_min_valid (i_min_valid),
`endif
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_sym_cnt   (o_sym_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    fcyc++;
    if (o_acs_en) begin
      acs_cnt++;
      if (fcyc < 64) acs_log[fcyc] = 1'b1;
    end
    if (o_norm) begin
      norm_cnt++;
      if (norm_cnt == 1) norm_i1 = acs_cnt;
      else if (norm_cnt == 2) norm_i2 = acs_cnt;
      if (!o_acs_en) norm_orphan++;
    end
    if (o_tb_start) begin tb_cnt++; tb_at = fcyc; end
    if (o_done) begin done_cnt++; done_at = fcyc; end
    if (o_pm_clr) pmclr_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    fcyc = 0; acs_log = '0; acs_cnt = 0; norm_cnt = 0; norm_i1 = 0; norm_i2 = 0;
    norm_orphan = 0; tb_cnt = 0; tb_at = 0; done_cnt = 0; done_at = 0; pmclr_cnt = 0;
  endtask

  // Drives one frame cycle by cycle; inputs set at negedge k act in cycle k.
  // nv==0 means valid held high from the first RUN cycle on.
  task automatic run_frame(input string tag, input logic [15:0] len,
                           input logic [31:0] vpat, input int nv,
                           input int min_k, input int xstart_k, input int budget);
    bit done_seen = 0;
    for (int k = 0; k < budget && !done_seen; k++) begin
      @(negedge clk);
      if (k > 0 && o_done) done_seen = 1;
      if (k == 0) clear_obs();
      i_start     = (k == 0) || (k == xstart_k);
      i_frame_len = (k == 0) ? len : ((k == xstart_k) ? 16'd50 : 16'd0);
      if (k < 2)        i_rx_valid = 1'b0;
      else if (nv == 0) i_rx_valid = 1'b1;
      else              i_rx_valid = (k - 2 < nv) ? vpat[k-2] : 1'b0;
      i_rx_data   = SLICED_INPUT_NUM'(k);
      i_min_valid = (k >= min_k);
      i_tb_done   = o_tb_start;
    end
    i_start = 1'b0; i_rx_valid = 1'b0; i_tb_done = 1'b0; i_min_valid = 1'b0;
    check({tag, "_done_seen"}, 64'(done_seen), 64'd1);
    @(negedge clk);
    check({tag, "_idle"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    rst = 1'b0; i_start = 1'b0; i_frame_len = '0; i_rx_valid = 1'b0;
    i_rx_data = '0; i_tb_done = 1'b0; i_min_valid = 1'b0;
    #1;
    check("reset_outs", 64'({o_rx_ready, o_acs_en, o_pm_clr, o_norm, o_tb_start,
                             o_busy, o_done, o_bm_data, o_sym_cnt}), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // len 4, continuous; stray start with len 50 during RUN; MINSRCH held off
    run_frame("f1", 16'd4, 32'd0, 0, 14, 3, 60);
    check("f1_acs_log", acs_log, 64'hF0);
    check("f1_sym_cnt", 64'(o_sym_cnt), 64'd4);
    check("f1_bm_data", 64'(o_bm_data), 64'd5);
    check("f1_pm_clr",  64'(pmclr_cnt), 64'd1);
    check("f1_tb_cnt",  64'(tb_cnt), 64'd1);
    check("f1_tb_at",   64'(tb_at), 64'(F1_TB));
    check("f1_done_at", 64'(done_at), 64'(F1_DN));
    check("f1_done_cnt", 64'(done_cnt), 64'd1);

    // len 3, valid 1,0,1,0,1 -> strobes mirror the pattern two cycles later
    run_frame("f2", 16'd3, 32'b10101, 5, 0, -1, 60);
    check("f2_acs_log", acs_log, 64'h150);
    check("f2_sym_cnt", 64'(o_sym_cnt), 64'd3);
    check("f2_bm_data", 64'(o_bm_data), 64'd6);
    check("f2_tb_at",   64'(tb_at), 64'(F2_TB));
    check("f2_done_at", 64'(done_at), 64'(F2_DN));

    // zero-length frame: LOAD then DONE only
    run_frame("f3", 16'd0, 32'd0, 0, 0, -1, 20);
    check("f3_acs_cnt", 64'(acs_cnt), 64'd0);
    check("f3_tb_cnt",  64'(tb_cnt), 64'd0);
    check("f3_done_at", 64'(done_at), 64'd2);
    check("f3_pm_clr",  64'(pmclr_cnt), 64'd1);

    // len 130: normalize on the 64th and 128th strobe only
    run_frame("f4", 16'd130, 32'd0, 0, 0, -1, 300);
    check("f4_acs_cnt",  64'(acs_cnt), 64'd130);
    check("f4_norm_cnt", 64'(norm_cnt), 64'd2);
    check("f4_norm_i1",  64'(norm_i1), 64'd64);
    check("f4_norm_i2",  64'(norm_i2), 64'd128);
    check("f4_norm_orphan", 64'(norm_orphan), 64'd0);
    check("f4_sym_cnt",  64'(o_sym_cnt), 64'd130);

    // reset after two symbols abandons the frame
    @(negedge clk);
    clear_obs();
    i_start = 1'b1; i_frame_len = 16'd10; i_rx_valid = 1'b1;
    @(negedge clk); i_start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("rst_pre_cnt", 64'(o_sym_cnt), 64'd2);
    rst = 1'b0; i_rx_valid = 1'b0;
    #1;
    check("rst_mid_outs", 64'({o_rx_ready, o_acs_en, o_pm_clr, o_norm, o_tb_start,
                               o_busy, o_done, o_bm_data, o_sym_cnt}), 64'd0);
    repeat (3) @(negedge clk);
    check("rst_no_tb",   64'(tb_cnt), 64'd0);
    check("rst_no_done", 64'(done_cnt), 64'd0);
    rst = 1'b1;
    run_frame("f5", 16'd2, 32'd0, 0, 0, -1, 40);
    check("f5_pm_clr",  64'(pmclr_cnt), 64'd1);
    check("f5_acs_log", acs_log, 64'h30);
    check("f5_tb_cnt",  64'(tb_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_ctrl.md
VITERBI_CTRL -- requirements
Module: viterbi_ctrl

Interface
REQ-001 SHALL have parameter TB_DEPTH, default 32, minimum symbols received before traceback is permitted.
REQ-002 SHALL have parameter NORM_PERIOD, default 64, number of ACS steps between path-metric normalization pulses.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_start  input  1  one-cycle frame start request.
REQ-006 SHALL have port i_frame_len  input  16  frame length in symbols, sampled on accepted i_start.
REQ-007 SHALL have ports i_rx_valid  input  1 and o_rx_ready  output  1  as the symbol handshake.
REQ-008 SHALL have port i_rx_data  input  SLICED_INPUT_NUM  received symbol.
REQ-009 SHALL have port o_bm_data  output  SLICED_INPUT_NUM  registered symbol driven to the branch-metric unit.
REQ-010 SHALL have port o_acs_en  output  1  ACS update strobe, aligned with valid branch distances.
REQ-011 SHALL have ports o_pm_clr  output  1 (path-metric clear) and o_norm  output  1 (normalize request).
REQ-012 SHALL have ports o_tb_start  output  1 and i_tb_done  input  1  traceback handshake.
REQ-013 SHALL have ports o_busy  output  1, o_done  output  1, o_sym_cnt  output  16.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN, DRAIN, TB, DONE.
REQ-015 IDLE->LOAD on i_start; i_start outside IDLE SHALL be ignored.
REQ-016 LOAD SHALL last one cycle, assert o_pm_clr, clear o_sym_cnt, go RUN; if latched length is 0, go DONE instead.
REQ-017 RUN: o_rx_ready=1 while o_sym_cnt < latched length; handshake = i_rx_valid & o_rx_ready.
REQ-018 On handshake in cycle T: o_bm_data updated at end of T; o_acs_en high in cycle T+2 (one cycle for registered branch metric); o_sym_cnt increments at end of T.
REQ-019 Gaps in i_rx_valid SHALL produce matching gaps in o_acs_en; no strobe without a handshake.
REQ-020 After last handshake, RUN->DRAIN; DRAIN SHALL hold until the last o_acs_en has been issued, then go TB.
REQ-021 TB: o_tb_start one-cycle pulse on entry; hold until i_tb_done, then DONE; i_tb_done outside TB ignored.
REQ-022 DONE: o_done one-cycle pulse, return to IDLE.
REQ-023 If latched length < TB_DEPTH, traceback SHALL still run after DRAIN (short frame, no early traceback).
REQ-024 o_norm SHALL pulse coincident with every NORM_PERIOD-th o_acs_en in a frame; counter clears in LOAD.
REQ-025 o_busy=1 in every state except IDLE.
REQ-026 o_sym_cnt SHALL saturate at latched length, never wrap.

Reset
REQ-027 On rst low: state IDLE, all outputs 0, counters 0, latched length 0, immediately and asynchronously.
REQ-028 Reset mid-frame SHALL abandon the frame without o_done or o_tb_start.

Configuration
REQ-029 Macro ZERO_TAIL_EN: when defined, traceback starts from state 0 and TB is entered directly from DRAIN.
REQ-030 Without ZERO_TAIL_EN: extra state MINSRCH between DRAIN and TB, waiting on input i_min_valid (1 bit) before o_tb_start; port exists only then.

Structure
REQ-031 FSM state enum, TB_DEPTH/NORM_PERIOD defaults SHALL live in the shared parameter package alongside SLICED_INPUT_NUM.
REQ-032 Normalization counter SHALL be sub-module viterbi_norm_cnt; everything else flat.

Verification
REQ-033 frame_len=4, valid continuous -> 4 acs_en pulses at T+2, one tb_start, o_done after i_tb_done.
REQ-034 frame_len=3, valid 1,0,1,0,1 -> acs_en mirrors pattern delayed 2 cycles, o_sym_cnt ends at 3.
REQ-035 frame_len=0 -> LOAD then DONE, no tb_start, no acs_en.
REQ-036 frame_len=130, NORM_PERIOD=64 -> o_norm on 64th and 128th acs_en only.
REQ-037 rst low after 2 symbols -> all outputs 0, next i_start starts clean frame with o_pm_clr.
REQ-038 i_start asserted during RUN -> ignored, frame completes with original length.
